seq_mult_param: RTL and testbench



---
 rtl/seq_mult_param.sv | 153 +++++++++++++++
 tb/tb_seq_mult_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Iterative shift-add multiplier: WIDTH-bit operands, radix-2 or radix-4 steps, signed/unsigned at runtime.
// Optional early termination when the remaining multiplier is zero: define MULT_EARLY_TERM_EN.
module seq_mult_param #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int PW = 2 * WIDTH;
  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT            stateR;
  logic [PW-1:0]    mcandR;
  logic [PW-1:0]    mcand3R;
  logic [PW-1:0]    accR;
  logic [WIDTH-1:0] mplrR;
  logic [CW-1:0]    cntR;
  logic             negR;

  logic [PW-1:0]    addendS;
  logic [PW-1:0]    mcandNextS;
  logic [WIDTH-1:0] mplrNextS;
  logic [WIDTH-1:0] magAS;
  logic [WIDTH-1:0] magBS;
  logic             calcLastS;
  logic             acceptS;

  // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // Operand magnitudes, digit selection and next-step values.
  always_comb begin
    magAS      = magnitude(a, is_signed);
    magBS      = magnitude(b, is_signed);
    mcandNextS = mcandR << RADIX_BITS;
    mplrNextS  = mplrR >> RADIX_BITS;
    acceptS    = start && ((stateR == IDLE) || (stateR == DONE));
    addendS    = '0;
    if (RADIX_BITS == 2) begin
      case (mplrR[1:0])
        2'd0:    addendS = '0;
        2'd1:    addendS = mcandR;
        2'd2:    addendS = mcandR << 1;
        2'd3:    addendS = mcand3R;
        default: addendS = '0;
      endcase
    end else begin
      addendS = mplrR[0] ? mcandR : '0;
    end
`ifdef MULT_EARLY_TERM_EN
    calcLastS = (cntR == CW'(0)) || (mplrNextS == '0);
`else
    calcLastS = (cntR == CW'(0));
`endif
  end

  // Control FSM and datapath registers; outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR  <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcandR  <= '0;
      mcand3R <= '0;
      accR    <= '0;
      mplrR   <= '0;
      cntR    <= '0;
      negR    <= 1'b0;
    end else if (acceptS) begin
      stateR  <= CALC;
      busy    <= 1'b1;
      done    <= 1'b0;
      mcandR  <= PW'(magAS);
      mcand3R <= PW'(magAS) + (PW'(magAS) << 1);
      accR    <= '0;
      mplrR   <= magBS;
      cntR    <= CW'(N - 1);
      negR    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else begin
      case (stateR)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        CALC: begin
          accR    <= accR + addendS;
          mcandR  <= mcandNextS;
          // 3*mcand kept alongside mcand so radix-4 digit 3 needs only an adder.
          mcand3R <= mcandNextS + (mcandNextS << 1);
          mplrR   <= mplrNextS;
          cntR    <= cntR - CW'(1);
          stateR  <= calcLastS ? FIX : CALC;
        end
        FIX: begin
          product <= negR ? (~accR + PW'(1)) : accR;
          stateR  <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        DONE: begin
          done   <= 1'b0;
          stateR <= IDLE;
        end
        default: begin
          stateR <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  seq_mult_param_chk chk (
    .clk  (clk),
    .rst  (rst),
    .busy (busy),
    .done (done)
  );
endmodule

// Handshake properties of the multiplier outputs.
module seq_mult_param_chk (
  input logic clk,
  input logic rst,
  input logic busy,
  input logic done
);
  doneNotBusy: assert property (@(posedge clk) disable iff (rst) done |-> !busy);
  donePulse:   assert property (@(posedge clk) disable iff (rst) done |=> !done);
endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench: radix-2 and radix-4 instances checked against plain-arithmetic products and latencies.
module tb_seq_mult_param;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          startA, startB, isSigned;
  logic [W-1:0]  a, b;
  logic          busyA, doneA, busyB, doneB;
  logic [2*W-1:0] productA, productB;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(W), .RADIX_BITS(1)) dutA (
    .clk(clk), .rst(rst), .start(startA), .is_signed(isSigned), .a(a), .b(b),
    .busy(busyA), .done(doneA), .product(productA)
  );

  seq_mult_param #(.WIDTH(W), .RADIX_BITS(2)) dutB (
    .clk(clk), .rst(rst), .start(startB), .is_signed(isSigned), .a(a), .b(b),
    .busy(busyB), .done(doneB), .product(productB)
  );

  typedef struct {
    logic [63:0] prod;
    int          doneCyc;
  } expT;

  expT         qA[$];
  expT         qB[$];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic [63:0] heldA = 64'd0;
  logic [63:0] heldB = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] refProduct(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0]        ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (sgn) return sx * sy;
    else     return ux * uy;
  endfunction

  // Cycles from the accepting edge's cycle to the done cycle.
  function automatic int refLatency(input logic sgn, input logic [W-1:0] y, input int rb);
    int n;
`ifdef MULT_EARLY_TERM_EN
    logic [W-1:0] m;
    int           len;
`endif
    n = W / rb;
`ifdef MULT_EARLY_TERM_EN
    m = (sgn && y[W-1]) ? (~y + 32'd1) : y;
    len = 0;
    for (int i = 0; i < W; i++) if (m[i]) len = i + 1;
    n = (len + rb - 1) / rb;
    if (n < 1) n = 1;
`endif
    return n + 2;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monA
    expT e;
    if (rst) begin
      qA.delete();
      heldA = 64'd0;
    end else if (doneA) begin
      if (qA.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_doneA: done with no pending op at edge %0d", cyc);
      end else begin
        e = qA.pop_front();
        check("productA", productA, e.prod);
        check("latencyA", 64'(cyc), 64'(e.doneCyc));
        heldA = e.prod;
      end
    end else if (busyA) begin
      check("holdA", productA, heldA);
    end
  end

  always @(negedge clk) begin : monB
    expT e;
    if (rst) begin
      qB.delete();
      heldB = 64'd0;
    end else if (doneB) begin
      if (qB.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_doneB: done with no pending op at edge %0d", cyc);
      end else begin
        e = qB.pop_front();
        check("productB", productB, e.prod);
        check("latencyB", 64'(cyc), 64'(e.doneCyc));
        heldB = e.prod;
      end
    end else if (busyB) begin
      check("holdB", productB, heldB);
    end
  end

  // Drive one start pulse; the accepting edge index is cyc just after that edge.
  task automatic issue(input logic toA, input logic toB, input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y);
    expT e;
    isSigned = sgn;
    a = x;
    b = y;
    startA = toA;
    startB = toB;
    @(posedge clk);
    #1;
    e.prod = refProduct(sgn, x, y);
    if (toA) begin
      e.doneCyc = cyc + refLatency(sgn, y, 1) - 1;
      qA.push_back(e);
    end
    if (toB) begin
      e.doneCyc = cyc + refLatency(sgn, y, 2) - 1;
      qB.push_back(e);
    end
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((qA.size() != 0 || qB.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qA.size() != 0 || qB.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d/%0d ops pending after %0d cycles", qA.size(), qB.size(), n);
      qA.delete();
      qB.delete();
    end
  endtask

  task automatic checkResetState();
    check("rst_busyA", 64'(busyA), 64'd0);
    check("rst_doneA", 64'(doneA), 64'd0);
    check("rst_productA", productA, 64'd0);
    check("rst_busyB", 64'(busyB), 64'd0);
    check("rst_doneB", 64'(doneB), 64'd0);
    check("rst_productB", productB, 64'd0);
  endtask

  logic         dirS[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] dirA[12] = '{32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                             32'h1234_5678, 32'h0000_0055, 32'h0000_0055, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  logic [W-1:0] dirB[12] = '{32'd6, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
                             32'h9ABC_DEF0, 32'd1, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

  initial begin
    int n;
    logic [W-1:0] x, y;
    rst = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    isSigned = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      issue(1'b1, 1'b1, dirS[i], dirA[i], dirB[i]);
      waitDrain(60);
    end

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = (i % 8 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      issue(1'b1, 1'b1, 1'($urandom_range(0, 1)), x, y);
      waitDrain(60);
    end

    // Start mid-operation must be ignored.
    issue(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0567);
    repeat (5) @(negedge clk);
    a = 32'd1;
    b = 32'd1;
    isSigned = 1'b1;
    startA = 1'b1;
    @(posedge clk);
    #1 startA = 1'b0;
    waitDrain(60);

    // Start during the done cycle is accepted back-to-back.
    @(negedge clk);
    issue(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0001_0003);
    n = 0;
    while (!doneA && n < 60) begin
      @(negedge clk);
      n++;
    end
    issue(1'b1, 1'b0, 1'b1, 32'h8765_4321, 32'hF000_000F);
    waitDrain(60);

    // Reset mid-operation discards the result and suppresses done.
    @(negedge clk);
    issue(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_0001);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(negedge clk);
    issue(1'b1, 1'b1, 1'b1, 32'h0000_0009, 32'hFFFF_FFF9);
    waitDrain(60);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
